// File: rtl/tsic_host.sv
// ----------------------------------------------------------------------------
// tsic_host
// Host-side serial initiator for the temperature-sensor IC command port.
// Sends a 16-bit command as two 8N1 bytes (high byte first) and assembles
// the IC's two-byte reply into a 16-bit response word. The transmitter and
// receiver are independent, so full-duplex traffic is legal.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   snd_cmd      one-cycle request to send cmd (ignored while busy)
//   cmd[15:0]    command word, captured when snd_cmd is accepted
//   clr_resp_rdy clears resp_rdy
//   RX           serial data from the IC (asynchronous)
//   TX           serial data to the IC, idle high, driven from a flop
//   cmd_snt      one-cycle pulse after the low byte's stop bit completes
//   busy         high while a command is being transmitted
//   resp[15:0]   last complete response word
//   resp_rdy     high when resp holds a new word
//   frm_err      one-cycle pulse on a received byte whose stop bit is 0
// ----------------------------------------------------------------------------
module tsic_host #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    input  logic        clr_resp_rdy,
    input  logic        RX,
    output logic        TX,
    output logic        cmd_snt,
    output logic        busy,
    output logic [15:0] resp,
    output logic        resp_rdy,
    output logic        frm_err
);

    localparam int            CW        = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    // Preloading the counter makes the first sample land BAUD_DIV/2 clocks
    // after the edge detect while every sample uses the same terminal count.
    localparam logic [CW-1:0] RX_START  = CW'(BAUD_DIV - BAUD_DIV / 2);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, TX_HIGH, TX_LOW} tx_state_t;

    tx_state_t     state, state_nxt;
    logic [CW-1:0] tx_baud;
    logic [3:0]    tx_bit;     // 0 = start, 1..8 = data, 9 = stop
    logic [15:0]   cmd_q;
    logic          accept;
    logic          tx_bit_end;
    logic          tx_last;
    logic [7:0]    tx_byte;

    assign accept     = (state == IDLE) && snd_cmd;
    assign tx_bit_end = (tx_baud == BAUD_LAST);
    assign tx_last    = tx_bit_end && (tx_bit == 4'd9);
    assign tx_byte    = (state == TX_LOW) ? cmd_q[7:0] : cmd_q[15:8];
    assign busy       = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next state defaults to the current state first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (snd_cmd) state_nxt = TX_HIGH;
            TX_HIGH: if (tx_last) state_nxt = TX_LOW;
            TX_LOW:  if (tx_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= '0;
            tx_baud <= '0;
            tx_bit  <= '0;
            TX      <= 1'b1;
            cmd_snt <= 1'b0;
        end else begin
            cmd_snt <= 1'b0;
            if (accept) begin
                cmd_q   <= cmd;
                TX      <= 1'b0;          // start bit of the high byte
                tx_baud <= '0;
                tx_bit  <= '0;
            end else if (busy) begin
                if (!tx_bit_end) begin
                    tx_baud <= tx_baud + 1'b1;
                end else begin
                    tx_baud <= '0;
                    if (tx_bit == 4'd9) begin
                        tx_bit <= '0;
                        if (state == TX_HIGH) begin
                            TX <= 1'b0;   // low byte start, no idle gap
                        end else begin
                            TX      <= 1'b1;
                            cmd_snt <= 1'b1;
                        end
                    end else begin
                        tx_bit <= tx_bit + 1'b1;
                        // Bit tx_bit+1 carries data bit tx_bit, or stop after bit 8.
                        TX <= (tx_bit == 4'd8) ? 1'b1 : tx_byte[tx_bit[2:0]];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic          rx_s1, rx_s2, rx_prev;
    logic          rx_active;
    logic [CW-1:0] rx_baud;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [7:0]    hold;
    logic          ptr;        // 0 = expecting high byte, 1 = low byte
    logic          rx_sample;
    logic          byte_good;
    logic          word_done;

    assign rx_sample = rx_active && (rx_baud == BAUD_LAST);
    assign byte_good = rx_sample && (rx_bit == 4'd9) && rx_s2;
    assign word_done = byte_good && ptr;

    // NOTE: the synchronizer and edge history reset to 1 (line idle) so
    // leaving reset can never look like a start-bit falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_active <= 1'b0;
            rx_baud   <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            frm_err   <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            if (!rx_active) begin
                if (rx_prev && !rx_s2) begin
                    rx_active <= 1'b1;
                    rx_baud   <= RX_START;
                    rx_bit    <= '0;
                end
            end else if (!rx_sample) begin
                rx_baud <= rx_baud + 1'b1;
            end else begin
                rx_baud <= '0;
                if (rx_bit == 4'd0) begin
                    if (rx_s2) rx_active <= 1'b0;   // false start
                    else       rx_bit    <= 4'd1;
                end else if (rx_bit == 4'd9) begin
                    rx_active <= 1'b0;
                    if (!rx_s2) frm_err <= 1'b1;
                end else begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 1'b1;
                end
            end
        end
    end

    // Word assembly. A fresh command resynchronizes the byte pointer; a
    // completing word beats a simultaneous clear of resp_rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 1'b0;
            hold     <= '0;
            resp     <= '0;
            resp_rdy <= 1'b0;
        end else begin
            if (byte_good && !ptr) hold <= rx_shift;
            if (word_done)         resp <= {hold, rx_shift};

            if (accept)         ptr <= 1'b0;
            else if (byte_good) ptr <= ~ptr;

            if (word_done)                    resp_rdy <= 1'b1;
            else if (accept || clr_resp_rdy)  resp_rdy <= 1'b0;
        end
    end

endmodule
